// File: rtl/display_pkg.sv
// display_pkg: shared constants and FSM encoding for the display write arbiter.
package display_pkg;
  localparam int DIGITS = 8;
  localparam int ADDR_W = 3;
  localparam int DIN_W = 6;
  localparam logic DIN_MARK = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just above rr_last.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  always_comb begin
    idx = '0;
    // Walk from farthest to nearest so the source right after rr_last wins.
    for (int i = NREQ; i >= 1; i--)
      if (req[(int'(rr_last) + i) % NREQ]) idx = IW'((int'(rr_last) + i) % NREQ);
    gnt = (|req) ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/display_write_arbiter.sv
// display_write_arbiter: round-robin owner of the display write port; latches
// the winning frame and bursts its 8 digits from address 7 down to 0.
module display_write_arbiter
  import display_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   frame,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 W,
  output logic [ADDR_W-1:0]    WADD,
  output logic [DIN_W-1:0]     DIN
);
  localparam int IW = $clog2(NREQ);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0] frame_q, frame_d;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, win_idx;
  logic [NREQ-1:0] win_gnt, owner_oh;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req(req), .rr_last(rr_q), .gnt(win_gnt), .idx(win_idx)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    frame_d = frame_q;
    owner_d = owner_q;
    rr_d = rr_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = WRITE;
        cnt_d = ADDR_W'(DIGITS - 1);
        owner_d = win_idx;
        for (int i = 0; i < NREQ; i++) if (win_gnt[i]) frame_d = frame[32*i +: 32];
      end
      WRITE: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - ADDR_W'(1);
        state_d = (cnt_q == '0) ? DONE : WRITE;
      end
      DONE: begin
        rr_d = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      frame_q <= '0;
      owner_q <= '0;
      rr_q <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
    end
  end
  assign owner_oh = NREQ'(1) << owner_q;
  assign W = (state_q == WRITE);
  assign busy = (state_q != IDLE);
  assign gnt = busy ? owner_oh : '0;
  assign ack = (state_q == DONE) ? owner_oh : '0;
  assign WADD = cnt_q;
  assign DIN = {DIN_MARK, frame_q[{cnt_q, 2'b00} +: 4], DIN_MARK};
endmodule

// File: tb/tb_display_write_arbiter.sv
// tb_display_write_arbiter: directed stimulus with a write/ack scoreboard.
module tb_display_write_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req, ack, gnt;
  logic [63:0] frame;
  logic busy, W;
  logic [2:0] WADD;
  logic [5:0] DIN;
  typedef struct {logic [2:0] a; logic [5:0] d; logic [1:0] g;} wr_t;
  wr_t wq[$];
  logic [1:0] aq[$];
  int ack_cyc[$];
  int tests = 0, fails = 0, cyc = 0;

  display_write_arbiter #(.NREQ(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .frame(frame), .ack(ack), .gnt(gnt),
    .busy(busy), .W(W), .WADD(WADD), .DIN(DIN)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (W) begin
      tests++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected got WADD=%0d DIN=%b gnt=%b", WADD, DIN, gnt);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if ({WADD, DIN, gnt} !== {e.a, e.d, e.g}) begin
          fails++;
          $display("FAIL write got WADD=%0d DIN=%b gnt=%b want WADD=%0d DIN=%b gnt=%b",
                   WADD, DIN, gnt, e.a, e.d, e.g);
        end
      end
    end
    if (|ack) begin
      tests++;
      ack_cyc.push_back(cyc);
      if (aq.size() == 0) begin
        fails++;
        $display("FAIL ack_unexpected got ack=%b", ack);
      end else begin
        logic [1:0] ea;
        ea = aq.pop_front();
        if (ack !== ea || W !== 1'b0) begin
          fails++;
          $display("FAIL ack got ack=%b W=%b want ack=%b W=0", ack, W, ea);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_frame(input int s, input logic [31:0] f);
    for (int k = 7; k >= 0; k--)
      wq.push_back('{a: 3'(k), d: {1'b1, f[4*k +: 4], 1'b1}, g: 2'(1 << s)});
    aq.push_back(2'(1 << s));
  endtask

  task automatic wait_idle(input string n);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk({n, "_idle"}, 32'(busy), 0);
    chk({n, "_wq_drained"}, wq.size(), 0);
    chk({n, "_aq_drained"}, aq.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req = '0;
    frame = '0;
    #1;
    chk("rst_W", 32'(W), 0);
    chk("rst_WADD", 32'(WADD), 0);
    chk("rst_DIN", 32'(DIN), 32'b100001);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    // single source burst 0x87654321
    frame[31:0] = 32'h8765_4321;
    req = 2'b01;
    exp_frame(0, 32'h8765_4321);
    tick();
    req = '0;
    wait_idle("single");
    // both sources requesting, two frames back to back
    do_reset();
    frame = {32'h9999_9999, 32'h0000_0000};
    ack_cyc.delete();
    req = 2'b11;
    exp_frame(0, 32'h0000_0000);
    exp_frame(1, 32'h9999_9999);
    repeat (11) tick();
    req = '0;
    wait_idle("dual");
    chk("dual_ack_count", ack_cyc.size(), 2);
    if (ack_cyc.size() == 2) chk("dual_ack_gap", 32'(ack_cyc[1] - ack_cyc[0]), 10);
    // source 1 continuous, source 0 joins mid-burst
    do_reset();
    frame = {32'hA1B2_C3D4, 32'h5E6F_7081};
    req = 2'b10;
    exp_frame(1, 32'hA1B2_C3D4);
    exp_frame(0, 32'h5E6F_7081);
    exp_frame(1, 32'hA1B2_C3D4);
    tick();
    repeat (3) tick();
    req = 2'b11;
    repeat (7) tick();
    req = 2'b10;
    repeat (10) tick();
    req = '0;
    wait_idle("rotate");
    // frame changes during burst are ignored
    do_reset();
    frame[31:0] = 32'h1234_5678;
    req = 2'b01;
    exp_frame(0, 32'h1234_5678);
    tick();
    req = '0;
    tick();
    tick();
    frame[31:0] = 32'hFFFF_FFFF;
    wait_idle("frame_hold");
    // async reset on the 4th write cycle
    do_reset();
    frame = {32'h2468_ACE0, 32'h1357_9BDF};
    req = 2'b11;
    for (int k = 7; k >= 5; k--)
      wq.push_back('{a: 3'(k), d: {1'b1, frame[4*k +: 4], 1'b1}, g: 2'b01});
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_W", 32'(W), 0);
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_busy", 32'(busy), 0);
    tick();
    tick();
    chk("midrst_partial_writes", wq.size(), 0);
    chk("midrst_no_ack", aq.size(), 0);
    rst_n = 1'b1;
    exp_frame(0, 32'h1357_9BDF);
    tick();
    req = '0;
    wait_idle("after_rst");
    // req dropped after one cycle; busy lasts exactly 9 cycles
    frame[31:0] = 32'h0F1E_2D3C;
    req = 2'b01;
    exp_frame(0, 32'h0F1E_2D3C);
    tick();
    req = '0;
    n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      n++;
      tick();
    end
    chk("busy_cycles", n, 9);
    wait_idle("drop");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
